// File: rtl/tx_4phase_sender_pkg.sv
// Shared definitions for the four-phase req/ack sender and its receiver-side peer.
package tx_4phase_sender_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SETUP    = 2'b01,
        REQ_HIGH = 2'b10,
        WAIT_LOW = 2'b11
    } state_t;

endpackage

// File: rtl/tx_4phase_sender_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; also usable for the receiver's req input.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tx_4phase_sender.sv
// Sending side of a four-phase return-to-zero req/ack link: accepts one word over
// valid/ready, presents it on a registered bus, then runs a full req/ack handshake.
module tx_4phase_sender
    import tx_4phase_sender_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  ack,
    output logic                  req,
    output logic [DATA_WIDTH-1:0] output_tx,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    state_t                state_q, state_d;
    logic                  ack_s;
    logic                  req_d;
    logic                  done_d;
    logic [DATA_WIDTH-1:0] tx_d;
    logic [CNT_WIDTH-1:0]  cnt_d;

    // Raw ack is asynchronous; only the synchronised copy reaches the FSM.
    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .reset(reset),
        .d    (ack),
        .q    (ack_s)
    );

    // Decoded from registers only; blocks a new word until the peer has returned to zero.
    assign in_ready = (state_q == IDLE) && !ack_s;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req        <= 1'b0;
            done       <= 1'b0;
            output_tx  <= '0;
            xfer_count <= '0;
        end else begin
            state_q    <= state_d;
            req        <= req_d;
            done       <= done_d;
            output_tx  <= tx_d;
            xfer_count <= cnt_d;
        end
    end

    // SETUP gives the data bus one full clock to settle before req rises.
    always_comb begin
        state_d = state_q;
        req_d   = req;
        done_d  = 1'b0;
        tx_d    = output_tx;
        cnt_d   = xfer_count;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (in_valid && in_ready) begin
                    tx_d    = in_data;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                state_d = REQ_HIGH;
            end
            REQ_HIGH: begin
                req_d = 1'b1;
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    done_d  = 1'b1;
                    cnt_d   = xfer_count + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_4phase_sender.sv
// Scoreboard bench for tx_4phase_sender: the driver queues expected words/counts,
// a monitor checks them when req rises and when done pulses.
module tb_tx_4phase_sender;

    localparam int unsigned DW   = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          ack = 1'b0;
    logic          req;
    logic [DW-1:0] output_tx;
    logic          busy;
    logic          done;
    logic [CW-1:0] xfer_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_word_q[$];
    logic [CW-1:0] exp_cnt_q[$];
    int            sw_count = 0;
    bit            rx_enable = 1'b0;
    int            ack_delay = 3;

    tx_4phase_sender #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SYNC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ack       (ack),
        .req       (req),
        .output_tx (output_tx),
        .busy      (busy),
        .done      (done),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare the bus when req rises and the counter when done pulses.
    initial begin : monitor
        logic          req_prev = 1'b0;
        logic          busy_prev = 1'b0;
        logic [DW-1:0] tx_prev = '0;
        logic [DW-1:0] w;
        logic [CW-1:0] c;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (req && !req_prev) begin
                    if (exp_word_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got word %0h expected none", output_tx);
                    end else begin
                        w = exp_word_q.pop_front();
                        check("word_order", 32'(output_tx), 32'(w));
                        check("data_before_req", 32'(tx_prev), 32'(w));
                    end
                end
                if (done) begin
                    if (exp_cnt_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got count %0d expected no done", xfer_count);
                    end else begin
                        c = exp_cnt_q.pop_front();
                        check("count_at_done", 32'(xfer_count), 32'(c));
                    end
                end
                if (busy && busy_prev) begin
                    check("tx_stable_busy", 32'(output_tx), 32'(tx_prev));
                    check("ready_low_busy", 32'(in_ready), 32'd0);
                end
            end
            req_prev  = req;
            busy_prev = busy;
            tx_prev   = output_tx;
        end
    end

    // Receiver model: raise ack after ack_delay cycles of req, measure req fall, return to zero.
    initial begin : receiver
        int edges;
        forever begin
            @(negedge clk);
            if (rx_enable && req && !ack && !reset) begin
                repeat (ack_delay - 1) @(negedge clk);
                ack = 1'b1;
                edges = 0;
                do begin
                    @(negedge clk);
                    edges++;
                end while (req && edges < 100);
                // Edges counted from ack rise: first sync flop samples on edge 1, req falls SYNC edges later.
                check("req_fall_latency", 32'(edges), 32'(SYNC + 1));
                repeat (2) @(negedge clk);
                ack = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] w, input bit keep_valid);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready %0b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_word_q.push_back(w);
        sw_count = (sw_count + 1) % (1 << CW);
        exp_cnt_q.push_back(CW'(sw_count));
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || exp_cnt_q.size() != 0 || ack) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: busy %0b pending %0d expected idle", name, busy, exp_cnt_q.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int t = 0;
        while (!req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_req_seen"}, 32'(req), 32'd1);
    endtask

    initial begin : stimulus
        bit dip, bad;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_tx", 32'(output_tx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(xfer_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Single transfer
        rx_enable = 1'b1;
        send_word(8'hA5, 1'b0);
        check("single_tx_on_bus", 32'(output_tx), 32'hA5);
        check("single_req_not_yet", 32'(req), 32'd0);
        wait_idle("single");
        check("single_count", 32'(xfer_count), 32'd1);

        // Back-to-back with in_valid held high
        send_word(8'h01, 1'b1);
        send_word(8'h02, 1'b1);
        send_word(8'h03, 1'b0);
        wait_idle("b2b");
        check("b2b_count", 32'(xfer_count), 32'd4);

        // Stalled ack
        rx_enable = 1'b0;
        send_word(8'h5A, 1'b0);
        wait_req("stall");
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (!req || !busy || in_ready || done) bad = 1'b1;
        end
        check("stall_held", 32'(bad), 32'd0);
        rx_enable = 1'b1;
        wait_idle("stall");
        check("stall_count", 32'(xfer_count), 32'd5);

        // Reset while in REQ_HIGH with ack high
        rx_enable = 1'b0;
        send_word(8'hC3, 1'b0);
        wait_req("rst_mid");
        ack = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(req), 32'd0);
        check("rst_mid_count", 32'(xfer_count), 32'd0);
        exp_cnt_q.delete();
        sw_count = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (SYNC) @(negedge clk);
        bad = 1'b0;
        repeat (4) begin
            if (in_ready) bad = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_ready_held_low", 32'(bad), 32'd0);
        ack = 1'b0;
        repeat (SYNC - 1) @(negedge clk);
        check("rst_mid_ready_before_sync", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst_mid_ready_after_sync", 32'(in_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);

        // Counter wrap: 17 transfers on a 4-bit counter
        rx_enable = 1'b1;
        for (int i = 0; i < 17; i++) send_word(DW'(8'h40 + i), i != 16);
        wait_idle("wrap");
        check("wrap_count", 32'(xfer_count), 32'd1);

        // Spurious ack while idle
        rx_enable = 1'b0;
        dip = 1'b0;
        bad = 1'b0;
        ack = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!in_ready) dip = 1'b1;
            if (req || busy || done) bad = 1'b1;
        end
        ack = 1'b0;
        repeat (SYNC + 1) begin
            @(negedge clk);
            if (req || busy || done) bad = 1'b1;
        end
        check("spurious_ready_dip", 32'(dip), 32'd1);
        check("spurious_no_activity", 32'(bad), 32'd0);
        check("spurious_ready_back", 32'(in_ready), 32'd1);
        check("spurious_count", 32'(xfer_count), 32'd1);

        check("words_drained", 32'(exp_word_q.size()), 32'd0);
        check("counts_drained", 32'(exp_cnt_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
